wb_trace_buffer: RTL and testbench

WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

---
 rtl/wb_trace_buffer_pkg.sv | 15 +
 rtl/wbt_fifo.sv | 60 ++++++
 rtl/wb_trace_buffer.sv | 88 ++++++++
 tb/tb_wb_trace_buffer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_trace_buffer_pkg.sv
// Shared widths and the trace-entry record for the write-back trace buffer.
package wb_trace_buffer_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned SEQ_W      = 16;
  localparam int unsigned DROP_W     = 8;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
    logic [SEQ_W-1:0]      seq;
  } trace_entry_t;

endpackage

// File: rtl/wbt_fifo.sv
// Show-ahead FIFO of trace entries; accepts a push while full only when a pop
// frees the head slot in the same cycle.
module wbt_fifo
  import wb_trace_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  trace_entry_t             i_wdata,
  output trace_entry_t             o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

  trace_entry_t    r_mem [DEPTH];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [PtrW:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_count == FullCnt);
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_clear) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/wb_trace_buffer.sv
// Captures CPU write-back register writes into a FIFO with sequence numbers,
// tracking dropped captures when the buffer is full.
module wb_trace_buffer
  import wb_trace_buffer_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter bit          DROP_R0 = 1'b1
) (
  input  logic                    clk_WBT,
  input  logic                    rstn_WBT,
  input  logic                    regWriteFlag_in,
  input  logic [REG_ADDR_W-1:0]   wAddr_in,
  input  logic [DATA_W-1:0]       wrData_in,
  input  logic                    clear_in,
  input  logic                    trace_ready,
  output logic                    trace_valid,
  output logic [REG_ADDR_W-1:0]   trace_addr,
  output logic [DATA_W-1:0]       trace_data,
  output logic [SEQ_W-1:0]        trace_seq,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty,
  output logic                    overflow,
  output logic [DROP_W-1:0]       drop_count
);

  logic [SEQ_W-1:0]  r_seq;
  logic              r_overflow;
  logic [DROP_W-1:0] r_drop_count;
  logic              w_req;
  logic              w_pop;
  logic              w_accept;
  logic              w_drop;
  logic              w_full;
  logic              w_empty;
  trace_entry_t      w_wdata;
  trace_entry_t      w_head;

  assign w_req    = regWriteFlag_in && !(DROP_R0 && (wAddr_in == '0));
  assign w_pop    = trace_ready && !w_empty;
  // A pop in the same cycle frees a slot, so a full buffer can still accept.
  assign w_accept = w_req && (!w_full || w_pop);
  assign w_drop   = w_req && w_full && !w_pop;
  assign w_wdata  = '{addr: wAddr_in, data: wrData_in, seq: r_seq};

  wbt_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk_WBT),
    .i_rst_n (rstn_WBT),
    .i_clear (clear_in),
    .i_push  (w_accept),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_head),
    .o_count (count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk_WBT or negedge rstn_WBT) begin
    if (!rstn_WBT) begin
      r_seq        <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (clear_in) begin
      r_seq        <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (w_accept) r_seq <= r_seq + 1'b1;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != '1) r_drop_count <= r_drop_count + 1'b1;
      end
    end
  end

  assign trace_valid = !w_empty;
  assign trace_addr  = w_head.addr;
  assign trace_data  = w_head.data;
  assign trace_seq   = w_head.seq;
  assign full        = w_full;
  assign empty       = w_empty;
  assign overflow    = r_overflow;
  assign drop_count  = r_drop_count;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Bench for wb_trace_buffer: stimulus table plus directed sequences, with a
// queue scoreboard holding the expected entries in capture order.
module tb_wb_trace_buffer;
  import wb_trace_buffer_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic        clk_WBT = 1'b0;
  logic        rstn_WBT = 1'b0;
  logic        regWriteFlag_in = 1'b0;
  logic [4:0]  wAddr_in = '0;
  logic [31:0] wrData_in = '0;
  logic        clear_in = 1'b0;
  logic        trace_ready = 1'b0;
  logic        trace_valid;
  logic [4:0]  trace_addr;
  logic [31:0] trace_data;
  logic [15:0] trace_seq;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;
  logic [7:0]  drop_count;

  wb_trace_buffer #(
    .DEPTH   (DEPTH),
    .DROP_R0 (1'b1)
  ) dut (
    .clk_WBT         (clk_WBT),
    .rstn_WBT        (rstn_WBT),
    .regWriteFlag_in (regWriteFlag_in),
    .wAddr_in        (wAddr_in),
    .wrData_in       (wrData_in),
    .clear_in        (clear_in),
    .trace_ready     (trace_ready),
    .trace_valid     (trace_valid),
    .trace_addr      (trace_addr),
    .trace_data      (trace_data),
    .trace_seq       (trace_seq),
    .count           (count),
    .full            (full),
    .empty           (empty),
    .overflow        (overflow),
    .drop_count      (drop_count)
  );

  always #5 clk_WBT = ~clk_WBT;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        rdy;
    logic        clr;
    logic [3:0]  exp_count;
    logic        exp_ovf;
    logic [7:0]  exp_drop;
  } vec_t;

  trace_entry_t q[$];
  logic [15:0]  m_seq;
  logic         m_ovf;
  logic [7:0]   m_drop;
  logic [15:0]  m_last_seq;
  int           n_checks = 0;
  int           n_errors = 0;
  vec_t         tbl[17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_seq  = '0;
    m_ovf  = 1'b0;
    m_drop = '0;
  endtask

  // Called at a falling edge: drive, check head, update model, advance one cycle.
  task automatic step(input logic we, input logic [4:0] a, input logic [31:0] d,
                      input logic rdy, input logic clr);
    logic pop;
    logic req;
    int   sz;
    regWriteFlag_in = we;
    wAddr_in        = a;
    wrData_in       = d;
    trace_ready     = rdy;
    clear_in        = clr;
    sz = q.size();
    if (sz > 0) begin
      check("head", {10'd0, trace_valid, trace_addr, trace_data, trace_seq},
            {10'd0, 1'b1, q[0].addr, q[0].data, q[0].seq});
    end else begin
      check("valid_empty", {63'd0, trace_valid}, 64'd0);
    end
    pop = rdy && (sz > 0);
    req = we && (a != 5'd0);
    if (clr) begin
      model_reset();
    end else begin
      if (pop) m_last_seq = q.pop_front().seq;
      if (req && (sz < DEPTH || pop)) begin
        q.push_back('{addr: a, data: d, seq: m_seq});
        m_seq = m_seq + 16'd1;
      end else if (req) begin
        m_ovf = 1'b1;
        if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
      end
    end
    @(posedge clk_WBT);
    @(negedge clk_WBT);
    regWriteFlag_in = 1'b0;
    trace_ready     = 1'b0;
    clear_in        = 1'b0;
    check("status", {48'd0, count, full, empty, trace_valid, overflow, drop_count},
          {48'd0, 4'(q.size()), q.size() == DEPTH, q.size() == 0, q.size() != 0, m_ovf, m_drop});
  endtask

  initial begin
    model_reset();
    m_last_seq = '0;
    tbl[0]  = '{1'b1, 5'd0,  32'h0000_0011, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 5'd3,  32'h0000_0005, 1'b0, 1'b0, 4'd1, 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 5'd4,  32'hA000_0004, 1'b0, 1'b0, 4'd2, 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 5'd5,  32'hA000_0005, 1'b0, 1'b0, 4'd3, 1'b0, 8'd0};
    tbl[4]  = '{1'b1, 5'd6,  32'hA000_0006, 1'b0, 1'b0, 4'd4, 1'b0, 8'd0};
    tbl[5]  = '{1'b1, 5'd7,  32'hA000_0007, 1'b0, 1'b0, 4'd5, 1'b0, 8'd0};
    tbl[6]  = '{1'b1, 5'd8,  32'hA000_0008, 1'b0, 1'b0, 4'd6, 1'b0, 8'd0};
    tbl[7]  = '{1'b1, 5'd9,  32'hA000_0009, 1'b0, 1'b0, 4'd7, 1'b0, 8'd0};
    tbl[8]  = '{1'b1, 5'd10, 32'hA000_000A, 1'b0, 1'b0, 4'd8, 1'b0, 8'd0};
    tbl[9]  = '{1'b1, 5'd11, 32'hA000_000B, 1'b0, 1'b0, 4'd8, 1'b1, 8'd1};
    tbl[10] = '{1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 4'd7, 1'b1, 8'd1};
    tbl[11] = '{1'b1, 5'd12, 32'hA000_000C, 1'b1, 1'b0, 4'd7, 1'b1, 8'd1};
    tbl[12] = '{1'b1, 5'd13, 32'hA000_000D, 1'b1, 1'b1, 4'd0, 1'b0, 8'd0};
    tbl[13] = '{1'b1, 5'd1,  32'h0000_00AB, 1'b0, 1'b0, 4'd1, 1'b0, 8'd0};
    tbl[14] = '{1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 4'd0, 1'b0, 8'd0};
    tbl[15] = '{1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 4'd0, 1'b0, 8'd0};
    tbl[16] = '{1'b1, 5'd0,  32'hDEAD_BEEF, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0};

    // Reset state while held in reset.
    #12;
    check("reset", {48'd0, count, full, empty, trace_valid, overflow, drop_count},
          {48'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0});
    @(negedge clk_WBT);
    rstn_WBT = 1'b1;
    @(negedge clk_WBT);

    foreach (tbl[i]) begin
      step(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].rdy, tbl[i].clr);
      check($sformatf("tbl%0d", i), {52'd0, count, overflow, drop_count},
            {52'd0, tbl[i].exp_count, tbl[i].exp_ovf, tbl[i].exp_drop});
    end
    // The entry captured right after the clear was popped with seq 0.
    check("seq_after_clear", {48'd0, m_last_seq}, 64'd0);

    // Saturating drop counter.
    step(1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 5'(i + 1), 32'hB000_0000 + i, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b1, 5'd2, 32'hC000_0000 + i, 1'b0, 1'b0);
    check("drop_sat", {55'd0, overflow, drop_count}, {55'd0, 1'b1, 8'd255});
    for (int i = 0; i < 8; i++) step(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    check("drain_last_seq", {48'd0, m_last_seq}, 64'd7);

    // Full with simultaneous capture and pop.
    step(1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 5'(i + 20), 32'hD000_0000 + i, 1'b0, 1'b0);
    step(1'b1, 5'd31, 32'hD000_0008, 1'b1, 1'b0);
    check("full_push_pop", {59'd0, count, full}, {59'd0, 4'd8, 1'b1});
    for (int i = 0; i < 8; i++) step(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    check("last_seq8", {48'd0, m_last_seq}, 64'd8);

    // Asynchronous reset between edges with five entries held.
    step(1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 5'(i + 1), 32'hE000_0000 + i, 1'b0, 1'b0);
    #2 rstn_WBT = 1'b0;
    #1;
    check("async_reset", {56'd0, count, empty, trace_valid, full, overflow},
          {56'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    model_reset();
    @(negedge clk_WBT);
    rstn_WBT = 1'b1;
    step(1'b1, 5'd7, 32'h7777_0000, 1'b0, 1'b0);
    step(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    check("seq_after_reset", {48'd0, m_last_seq}, 64'd0);

    // Mixed random traffic against the model.
    for (int i = 0; i < 80; i++) begin
      step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 4)), $urandom,
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 40) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
